// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    BUF   = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_stage_skid_buf.sv
// fetch_skid_buf: single-entry {pc, instr} holding register used while decode is stalled.
module fetch_skid_buf
  import instruction_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, imem request, IF/ID register, stall and redirect handling.
// Optional PERF_CNT_EN adds saturating stall/redirect event counters.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | request outstanding at pc
// BUF   | response captured in skid buffer while decode is stalled
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ifid_load, ifid_bubble, ifid_from_buf;
  logic            buf_load, buf_drain, buf_clear;
  logic            buf_full;
  logic [XLEN-1:0] buf_pc, buf_instr;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^{redirect_pc[1:0], buf_full};

  // Request and address decode only registered state, never stall or ready.
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_from_buf = 1'b0;
    buf_load      = 1'b0;
    buf_drain     = 1'b0;
    buf_clear     = 1'b0;
    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      ifid_bubble = 1'b1;
      buf_clear   = 1'b1;
      state_d     = FETCH;
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = BUF;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        BUF: begin
          if (!stall) begin
            ifid_from_buf = 1'b1;
            buf_drain     = 1'b1;
            state_d       = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_instr    <= NOP_INSTR;
    end else if (ifid_bubble) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (ifid_load) begin
      if_id_valid    <= 1'b1;
      if_id_pc       <= pc_q;
      if_id_pc_plus4 <= pc_q + 32'd4;
      if_id_instr    <= imem_rdata;
    end else if (ifid_from_buf) begin
      if_id_valid    <= 1'b1;
      if_id_pc       <= buf_pc;
      if_id_pc_plus4 <= buf_pc + 32'd4;
      if_id_instr    <= buf_instr;
    end
  end

  fetch_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .drain      (buf_drain),
    .clear      (buf_clear),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .full       (buf_full),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stall && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF))
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a queue-based reference model predicts
// the post-edge outputs each cycle, and an independent monitor compares them.
module tb_instruction_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instruction_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr)
`ifdef PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        cmp_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] stalls;
    logic [31:0] redirs;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural PC, a list of fetched-but-undelivered PCs, and IF/ID contents.
  logic [31:0] m_pc;
  logic        m_boot;
  logic [31:0] m_held[$];
  exp_t        m_out;

  task automatic m_deliver(input logic [31:0] p);
    m_out.valid    = 1'b1;
    m_out.cmp_pc   = 1'b1;
    m_out.pc       = p;
    m_out.pc_plus4 = p + 32'd4;
    m_out.instr    = mem_word(p);
  endtask

  task automatic m_bubble();
    m_out.valid  = 1'b0;
    m_out.cmp_pc = 1'b0;
    m_out.instr  = NOP;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] rpc,
                            input logic rdy, input logic rst);
    if (!rst) begin
      m_pc = RST_PC;
      m_boot = 1'b1;
      m_held.delete();
      m_out.valid = 1'b0; m_out.cmp_pc = 1'b1; m_out.pc = '0;
      m_out.pc_plus4 = '0; m_out.instr = NOP;
      m_out.stalls = '0; m_out.redirs = '0;
    end else begin
      if (s && m_out.stalls != 32'hFFFF_FFFF) m_out.stalls = m_out.stalls + 1;
      if (rv && m_out.redirs != 32'hFFFF_FFFF) m_out.redirs = m_out.redirs + 1;
      if (rv) begin
        m_pc = {rpc[31:2], 2'b00};
        m_held.delete();
        m_boot = 1'b0;
        m_bubble();
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_held.size() != 0) begin
        if (!s) m_deliver(m_held.pop_front());
      end else if (rdy) begin
        if (s) m_held.push_back(m_pc);
        else m_deliver(m_pc);
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_bubble();
      end
    end
    m_out.req  = !m_boot && (m_held.size() == 0);
    m_out.addr = m_pc;
    exp_q.push_back(m_out);
  endtask

  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic rst);
    @(negedge clk);
    stall = s; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy; rst_n = rst;
    model_step(s, rv, rpc, rdy, rst);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        chk("imem_addr", imem_addr, e.addr);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        chk("if_id_instr", if_id_instr, e.instr);
        if (e.cmp_pc) begin
          chk("if_id_pc", if_id_pc, e.pc);
          chk("if_id_pc_plus4", if_id_pc_plus4, e.pc_plus4);
        end
`ifdef PERF_CNT_EN
        chk("perf_stall_cycles", perf_stall_cycles, e.stalls);
        chk("perf_redirects", perf_redirects, e.redirs);
`endif
      end
    end
  end

  initial begin
    logic        s, rv, rdy, rst;
    logic [31:0] rpc;
    m_out = '{default: '0};
    // Reset, boot, then back-to-back fetch of 0x100 and 0x104.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // Two-cycle stall hitting the 0x104 response, then release.
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // Redirect to 0x2003 while stalled in the buffer state.
    cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 32'h0000_2003, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // Memory not ready for three cycles at 0x200.
    cyc(0, 1, 32'h0000_0200, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // PC wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // Reset asserted while holding a buffered instruction.
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom_range(0, 99) < 25);
      rv  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) != 0);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom_range(0, 15)))
                                        : $urandom;
      cyc(s, rv, rpc, rdy, rst);
    end
    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the 5-stage RISC-V pipeline: owns the program counter, issues single-cycle-handshake requests to instruction memory and drives the IF/ID pipeline register consumed by decode. It honours the load-use stall from the hazard detection unit by freezing PC and IF/ID. It honours branch/jump redirects from EX by reloading PC and squashing IF/ID to a NOP bubble. A one-entry skid buffer prevents losing an instruction returned during a stall.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and IF/ID this cycle (load-use hazard)
- redirect_valid  in  1  taken branch/jump resolved in EX
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address, equals current PC
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr
- imem_rdata  in  32  fetched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_pc_plus4  out  32  if_id_pc + 4
- if_id_instr  out  32  instruction, NOP (32'h0000_0013) when invalid

## Operation
- States: BOOT, FETCH, BUF.
- Reset (rst_n=0 at edge): pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=NOP, if_id_pc=0, if_id_pc_plus4=0, buffer empty. Outputs: imem_req=0, imem_addr=RESET_PC.
- BOOT: imem_req=0; next state FETCH unconditionally, unless redirect_valid=1, which applies the redirect rule.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & !stall: load IF/ID {valid=1, pc, rdata}; pc+=4.
  - ready & stall: capture {pc, rdata} in buffer; pc+=4; go to BUF; IF/ID holds.
  - !ready & !stall: IF/ID becomes bubble (valid=0, instr=NOP).
  - !ready & stall: IF/ID holds.
- BUF: imem_req=0. While stall=1, everything holds. On stall=0: IF/ID loaded from buffer (valid=1); go to FETCH.
- Redirect priority: redirect_valid overrides stall and every state. In that cycle:
  - pc={redirect_pc[31:2],2'b00};
  - IF/ID becomes bubble;
  - buffer discarded;
  - any imem response in that cycle dropped;
  - state becomes FETCH.
- imem_addr stays stable while imem_req=1 and imem_ready=0. The only exception is the cycle after a redirect.
- Arithmetic: pc+4 and pc_plus4 wrap modulo 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Fetch latency: an instruction accepted (FETCH, ready, !stall) at edge N appears on IF/ID outputs after edge N, i.e. during cycle N+1.
- Back-to-back throughput: 1 instruction/cycle while imem_ready=1 and stall=0.
- Redirect asserted in cycle N: imem_addr=target in cycle N+1; earliest valid target instruction in IF/ID is cycle N+2.
- Stall release from BUF: buffered instruction is in IF/ID one cycle after stall drops. The next request issues in that same following cycle, so there is one lost fetch slot.
- All outputs are registered except imem_req and imem_addr, which decode only state and pc (no combinational path from stall or imem_ready).

## Configuration
- PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0].
  - perf_stall_cycles increments each cycle with stall=1; perf_redirects increments each cycle with redirect_valid=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package holds:
  - NOP_INSTR=32'h0000_0013;
  - XLEN=32;
  - fetch state enum {BOOT, FETCH, BUF}.
- One sub-module, fetch_skid_buf: single-entry {pc, instr} buffer with load, drain and clear controls and a full flag. The FSM, PC and IF/ID register stay in the top module.

## Test plan
- Reset release with RESET_PC=32'h100 and imem_ready tied 1 -> cycle 1 BOOT with imem_req=0; addresses 0x100, 0x104, 0x108 on successive cycles. IF/ID valid from the cycle after the first request, with pc_plus4=0x104.
- stall=1 for 2 cycles in the same cycle as a ready response for 0x104:
  - instruction is buffered and imem_req=0 during the stall;
  - IF/ID holds 0x100;
  - after release, IF/ID=0x104, then fetch resumes at 0x108 with no drop or duplicate.
- redirect_valid=1 with redirect_pc=32'h2003 while stall=1 and in BUF -> next cycle imem_addr=0x2000, IF/ID valid=0 and instr=NOP, buffered instruction never appears.
- imem_ready low for 3 cycles at 0x200 -> imem_addr held at 0x200, IF/ID bubbles (valid=0) each cycle, then IF/ID pc=0x200 once ready is high.
- pc at 32'hFFFF_FFFC with ready -> next imem_addr=0, if_id_pc_plus4=0.
- rst_n=0 asserted mid-stream in BUF -> next cycle state BOOT, imem_req=0, if_id_valid=0, buffer empty. With PERF_CNT_EN defined, both counters read 0.
